// File: rtl/ddr_cmd_arbiter.sv
// Two-requester command arbiter for one DDR controller port: display reads vs. Mandelbrot writes.
// Calibration-gated, urgent-read priority, round-robin fairness and a write starvation override.
module ddr_cmd_arbiter #(
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_calib_done,
    input  logic        rd_req,
    input  logic        rd_urgent,
    input  logic [29:0] rd_addr,
    input  logic [5:0]  rd_bl,
    output logic        rd_gnt,
    input  logic        wr_req,
    input  logic [29:0] wr_addr,
    input  logic [5:0]  wr_bl,
    output logic        wr_gnt,
    input  logic [6:0]  wr_fifo_count,
    input  logic        cmd_full,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    output logic        calib_ok,
    output logic [15:0] rd_cmd_count,
    output logic [15:0] wr_cmd_count
);

    typedef enum logic [1:0] {CALIB, IDLE, ISSUE, GAP} state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

    state_t     state_reg;
    logic       calib_meta_reg;
    logic       last_wr_reg;
    logic [7:0] starve_reg;

    logic rd_elig;
    logic wr_elig;
    logic starved;
    logic pick_wr;
    logic decide;

    // A write is only worth issuing once its whole burst already sits in the controller FIFO.
    assign rd_elig = rd_req;
    assign wr_elig = wr_req && (wr_fifo_count >= ({1'b0, wr_bl} + 7'd1));
    assign starved = starve_reg >= STARVE_LIM;
    assign pick_wr = wr_elig &&
                     (starved || (!(rd_elig && rd_urgent) && (!rd_elig || !last_wr_reg)));
    assign decide  = (state_reg == IDLE) && calib_ok && !cmd_full && (rd_elig || wr_elig);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= CALIB;
            calib_meta_reg <= 1'b0;
            calib_ok       <= 1'b0;
            cmd_en         <= 1'b0;
            rd_gnt         <= 1'b0;
            wr_gnt         <= 1'b0;
            cmd_instr      <= 3'b000;
            cmd_bl         <= 6'd0;
            cmd_byte_addr  <= 30'd0;
            rd_cmd_count   <= 16'd0;
            wr_cmd_count   <= 16'd0;
            last_wr_reg    <= 1'b0;
        end else begin
            calib_meta_reg <= mem_calib_done;
            calib_ok       <= calib_meta_reg;
            cmd_en         <= 1'b0;
            rd_gnt         <= 1'b0;
            wr_gnt         <= 1'b0;
            case (state_reg)
                CALIB: begin
                    if (calib_ok) state_reg <= IDLE;
                end
                IDLE: begin
                    if (!calib_ok) begin
                        state_reg <= CALIB;
                    end else if (decide) begin
                        state_reg <= ISSUE;
                        cmd_en    <= 1'b1;
                        if (pick_wr) begin
                            wr_gnt        <= 1'b1;
                            cmd_instr     <= 3'b000;
                            cmd_bl        <= wr_bl;
                            cmd_byte_addr <= {wr_addr[29:2], 2'b00};
                        end else begin
                            rd_gnt        <= 1'b1;
                            cmd_instr     <= 3'b001;
                            cmd_bl        <= rd_bl;
                            cmd_byte_addr <= {rd_addr[29:2], 2'b00};
                        end
                    end
                end
                ISSUE: begin
                    // The command in flight always completes, even if calibration drops.
                    state_reg   <= GAP;
                    last_wr_reg <= wr_gnt;
                    if (wr_gnt) wr_cmd_count <= wr_cmd_count + 16'd1;
                    else        rd_cmd_count <= rd_cmd_count + 16'd1;
                end
                GAP: begin
                    state_reg <= calib_ok ? IDLE : CALIB;
                end
                default: state_reg <= CALIB;
            endcase
        end
    end

    // Counts IDLE cycles an eligible write loses, including cycles blocked by cmd_full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_reg <= 8'd0;
        end else if (wr_gnt || !wr_elig) begin
            starve_reg <= 8'd0;
        end else if ((state_reg == IDLE) && !(decide && pick_wr) && (starve_reg != 8'hFF)) begin
            starve_reg <= starve_reg + 8'd1;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed bench for ddr_cmd_arbiter: calibration gating, priority, fairness, data gate,
// starvation override, back-pressure and asynchronous reset during a command.
module tb_ddr_cmd_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_calib_done = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_urgent = 1'b0;
    logic [29:0] rd_addr = '0;
    logic [5:0]  rd_bl = '0;
    logic        rd_gnt;
    logic        wr_req = 1'b0;
    logic [29:0] wr_addr = '0;
    logic [5:0]  wr_bl = '0;
    logic        wr_gnt;
    logic [6:0]  wr_fifo_count = '0;
    logic        cmd_full = 1'b0;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        calib_ok;
    logic [15:0] rd_cmd_count;
    logic [15:0] wr_cmd_count;

    int checks = 0;
    int errors = 0;
    int en_seen = 0;

    ddr_cmd_arbiter #(.STARVE_LIMIT(16)) dut (
        .clk(clk), .reset_n(reset_n), .mem_calib_done(mem_calib_done),
        .rd_req(rd_req), .rd_urgent(rd_urgent), .rd_addr(rd_addr), .rd_bl(rd_bl),
        .rd_gnt(rd_gnt), .wr_req(wr_req), .wr_addr(wr_addr), .wr_bl(wr_bl),
        .wr_gnt(wr_gnt), .wr_fifo_count(wr_fifo_count), .cmd_full(cmd_full),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .calib_ok(calib_ok),
        .rd_cmd_count(rd_cmd_count), .wr_cmd_count(wr_cmd_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_en) begin
            en_seen++;
            $display("cmd %s addr=%h bl=%0d rd_gnt=%0b wr_gnt=%0b",
                     (cmd_instr == 3'b001) ? "RD" : "WR", cmd_byte_addr, cmd_bl, rd_gnt, wr_gnt);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int snap;
    int reads;
    logic found;

    initial begin
        // Reset state
        tick(); tick();
        check("rst_cmd_en", cmd_en, 0);
        check("rst_rd_gnt", rd_gnt, 0);
        check("rst_wr_gnt", wr_gnt, 0);
        check("rst_calib_ok", calib_ok, 0);
        check("rst_instr", cmd_instr, 0);
        check("rst_addr", cmd_byte_addr, 0);
        check("rst_counts", {rd_cmd_count, wr_cmd_count}, 0);
        reset_n = 1'b1;

        // Calibration gating with both requests up and write data available
        rd_req = 1; rd_addr = 30'h100; rd_bl = 3;
        wr_req = 1; wr_addr = 30'h207; wr_bl = 7; wr_fifo_count = 8;
        repeat (50) tick();
        check("calib_no_cmd", en_seen, 0);
        check("calib_low", calib_ok, 0);
        mem_calib_done = 1;                       // cycle N
        tick(); check("calib_n1", calib_ok, 0);
        tick(); check("calib_n2", calib_ok, 1);
        check("calib_n2_en", cmd_en, 0);
        tick(); check("calib_n3_en", cmd_en, 0);
        tick();                                   // N+4: first command
        check("first_en", cmd_en, 1);
        check("first_wr_gnt", wr_gnt, 1);
        check("first_instr", cmd_instr, 3'b000);
        check("first_addr", cmd_byte_addr, 30'h204);
        check("first_bl", cmd_bl, 7);

        // Urgent read beats an eligible write
        tick();                                   // GAP
        rd_urgent = 1; rd_addr = 30'h500003; rd_bl = 63;
        wr_fifo_count = 64; wr_bl = 63;
        tick();                                   // IDLE
        tick();                                   // ISSUE
        check("urg_rd_gnt", rd_gnt, 1);
        check("urg_wr_gnt", wr_gnt, 0);
        check("urg_instr", cmd_instr, 3'b001);
        check("urg_addr", cmd_byte_addr, 30'h500000);
        check("urg_bl", cmd_bl, 63);
        tick();                                   // GAP
        check("urg_counts", {rd_cmd_count, wr_cmd_count}, {16'd1, 16'd1});

        // Round robin: last was read, so write leads
        rd_urgent = 0;
        for (int i = 0; i < 6; i++) begin
            tick();                               // IDLE
            tick();                               // ISSUE
            check("rr_wr_gnt", wr_gnt, (i % 2 == 0) ? 1 : 0);
            check("rr_rd_gnt", rd_gnt, (i % 2 == 0) ? 0 : 1);
            tick();                               // GAP
        end
        check("rr_counts", {rd_cmd_count, wr_cmd_count}, {16'd4, 16'd4});

        // Write data gate: 31 words for a 32-word burst is not enough
        rd_req = 0; wr_bl = 31; wr_fifo_count = 31;
        snap = en_seen;
        repeat (10) tick();
        check("gate_blocked", en_seen - snap, 0);
        wr_fifo_count = 32;
        tick();
        check("gate_wr_gnt", wr_gnt, 1);
        check("gate_bl", cmd_bl, 31);
        tick();                                   // GAP
        check("gate_wr_count", wr_cmd_count, 5);

        // Starvation: urgent reads hold off the write for exactly 16 IDLE cycles
        rd_req = 1; rd_urgent = 1;
        reads = 0; found = 0;
        for (int c = 0; c < 120 && !found; c++) begin
            tick();
            if (rd_gnt) reads++;
            if (wr_gnt) found = 1;
        end
        check("starve_found", found, 1);
        check("starve_reads", reads, 16);
        tick();
        check("starve_cleared", dut.starve_reg, 0);
        check("starve_counts", {rd_cmd_count, wr_cmd_count}, {16'd20, 16'd6});

        // Back-pressure: starve counter keeps counting while cmd_full blocks decisions
        rd_urgent = 0; cmd_full = 1;
        snap = en_seen;
        repeat (20) tick();
        check("full_blocked", en_seen - snap, 0);
        cmd_full = 0;
        tick();
        check("full_rel_en", cmd_en, 1);
        check("full_rel_wr", wr_gnt, 1);
        tick();                                   // GAP
        tick();                                   // IDLE: read wins round robin
        tick();                                   // ISSUE
        check("pre_rst_en", cmd_en, 1);
        check("pre_rst_rd", rd_gnt, 1);
        #2 reset_n = 0;
        #1;
        check("async_rst_en", cmd_en, 0);
        check("async_rst_gnt", {rd_gnt, wr_gnt}, 0);
        check("async_rst_cnt", rd_cmd_count, 0);
        tick();
        reset_n = 1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_arbiter.md
# ddr_cmd_arbiter

Shares one DDR memory-controller command port between two requesters: the display pixel fetcher (reads) and the Mandelbrot pixel writer (writes). Gates all traffic on memory calibration and arbitrates with urgent-read priority, round-robin fairness and a write starvation guard. Issues one registered command per grant, and withholds writes until the controller write FIFO holds the full burst. Sits between the fetch/compute engines and the controller's port command/FIFO signals.

## Interface
- `STARVE_LIMIT`, default 16: cycles an eligible write may wait before it overrides urgent reads (1..255).
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_calib_done` in 1: controller calibration flag; async, 2-flop synchronised internally.
- `rd_req` in 1: read request; hold high with `rd_addr`/`rd_bl` stable until `rd_gnt`.
- `rd_urgent` in 1: display FIFO low; read takes priority.
- `rd_addr` in 30: read byte address.
- `rd_bl` in 6: read burst length minus 1.
- `rd_gnt` out 1: one-cycle grant pulse.
- `wr_req` in 1: write request; same holding rule.
- `wr_addr` in 30: write byte address.
- `wr_bl` in 6: write burst length minus 1.
- `wr_gnt` out 1: one-cycle grant pulse.
- `wr_fifo_count` in 7: controller write-FIFO word count.
- `cmd_full` in 1: controller command FIFO full.
- `cmd_en` out 1: command strobe.
- `cmd_instr` out 3: 3'b001 read, 3'b000 write.
- `cmd_bl` out 6: burst length minus 1.
- `cmd_byte_addr` out 30: byte address, bits [1:0] forced to 0.
- `calib_ok` out 1: synchronised calibration flag.
- `rd_cmd_count` out 16: issued reads, wraps.
- `wr_cmd_count` out 16: issued writes, wraps.

## Operation
- States: CALIB, IDLE, ISSUE, GAP.
- CALIB: no commands. Go to IDLE when the synchronised calibration flag is 1.
- IDLE: if calibration is lost, go to CALIB. Else if `cmd_full`=0 and any request is eligible, pick a winner, latch its command fields, and go to ISSUE.
- Eligibility:
  - read is eligible when `rd_req`=1;
  - write is eligible when `wr_req`=1 and `wr_fifo_count` >= `wr_bl`+1 (7-bit compare, `wr_bl` zero-extended).
- Priority, highest first:
  1. write when starve counter >= `STARVE_LIMIT`;
  2. read when `rd_urgent`=1;
  3. round-robin on a last-granted bit: reset value means read was last, so a tie after reset goes to write.
- ISSUE: `cmd_en`=1 and the matching grant =1 for exactly one cycle. Update the last-granted bit. Increment the matching command counter. Always go to GAP.
- GAP: all strobes 0. The requester updates or drops its request in this cycle. Next state is IDLE, or CALIB if calibration is lost.
- Starve counter, 8 bits, saturating:
  - increments each IDLE cycle in which a write is eligible but not granted;
  - clears on `wr_gnt`, or whenever the write is not eligible.
- `cmd_instr`, `cmd_bl` and `cmd_byte_addr` hold their last values outside ISSUE.
- Requests not held stable until grant are a protocol violation. Behaviour in that case is unspecified.

## Timing
- Reset values: state=CALIB; `cmd_en`, `rd_gnt`, `wr_gnt`, `calib_ok` = 0; `cmd_instr`=3'b000; `cmd_bl`, `cmd_byte_addr`, both counters, starve counter, last-granted bit = 0.
- `mem_calib_done` rising at cycle N: `calib_ok`=1 at cycle N+2. IDLE entered at N+3.
- Request eligible in IDLE cycle N: `cmd_en` and grant high in N+1, GAP in N+2, IDLE in N+3. Peak rate is one command per 3 cycles.
- `cmd_full`=1 in an IDLE cycle: no decision that cycle. Re-evaluate on the next cycle; starve counter still counts.
- Calibration lost while in ISSUE: the command in flight still completes, then GAP, then CALIB.
- `reset_n` asserted mid-ISSUE: `cmd_en` and grants drop immediately (asynchronously). No command is counted.
- Counters wrap 16'hFFFF→0 with no flag.

## Test plan
- Reset/calibration: hold `mem_calib_done`=0 for 50 cycles with both requests high. Required: no `cmd_en`. Raise the flag: first `cmd_en` 4 cycles later, which is a write if its FIFO is filled, else a read.
- Urgent read: `rd_req`=`rd_urgent`=1 with `rd_addr`=30'h500003, `rd_bl`=63; `wr_req`=1 with `wr_fifo_count`=64, `wr_bl`=63. Required: read first, `cmd_instr`=001, `cmd_byte_addr`=30'h500000, `cmd_bl`=63.
- Round-robin: both requests held, no urgency, across 6 grants. Required: order wr,rd,wr,rd,wr,rd; `rd_cmd_count`=`wr_cmd_count`=3.
- Write data gate: `wr_bl`=31 with `wr_fifo_count`=31. Required: no write. Set count to 32: `wr_gnt` 1 cycle later.
- Starvation: `STARVE_LIMIT`=16, `rd_urgent` and `rd_req` held at 1, write eligible. Required: `wr_gnt` no later than 16 IDLE cycles after the write becomes eligible. Starve counter reads 0 the cycle after `wr_gnt`.
- Back-pressure and reset: `cmd_full`=1 for 20 cycles blocks `cmd_en`; release gives a grant 1 cycle later. Asserting `reset_n`=0 during ISSUE clears `cmd_en` within the same cycle.
